// File: rtl/entropy_streamer.sv
// entropy_streamer: gathers words from several entropy sources, combines them
// (XOR of one word per channel, or round-robin pass-through), slices each word
// into bytes LSB first, buffers the bytes in a FIFO and feeds them to a UART
// transmitter over its start/busy handshake. Single-byte host commands
// received over the UART control streaming, mode, overflow and soft reset.
module entropy_streamer #(
    parameter int N_CHANNELS   = 2,
    parameter int WORD_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CHANNELS-1:0]            word_valid,
    input  logic [N_CHANNELS*WORD_WIDTH-1:0] word_data,
    input  logic                             rx_received,
    input  logic [7:0]                       rx_byte,
    input  logic                             tx_busy,
    output logic                             tx_start,
    output logic [7:0]                       tx_byte,
    output logic                             soft_reset,
    output logic                             streaming,
    output logic                             mode,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int PW    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic {PK_IDLE, PK_PUSH} pk_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

    logic                  cmd_valid;
    logic [7:0]            cmd_byte;
    logic                  cmd_go, cmd_stop, cmd_mode, cmd_clear, cmd_reset, abort;

    logic [WORD_WIDTH-1:0] hold [N_CHANNELS];
    logic [N_CHANNELS-1:0] fresh;
    logic [PW-1:0]         rr_ptr;
    logic [WORD_WIDTH-1:0] xor_word, rr_word, emit_word;
    logic                  rr_hit, emit_xor, emit_rr, emit;

    pk_state_t             pk_state;
    logic [WORD_WIDTH-1:0] pk_word;
    logic [IW-1:0]         pk_idx;
    logic                  push;

    logic [7:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  full, empty, pop, push_ok;

    tx_state_t             tx_state;

    // Register the received byte so commands act one cycle after reception
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
        end else begin
            cmd_valid <= rx_received;
            cmd_byte  <= rx_byte;
        end
    end

    assign cmd_go    = cmd_valid && (cmd_byte == 8'h67);
    assign cmd_stop  = cmd_valid && (cmd_byte == 8'h73);
    assign cmd_mode  = cmd_valid && (cmd_byte == 8'h6D);
    assign cmd_clear = cmd_valid && (cmd_byte == 8'h63);
    assign cmd_reset = cmd_valid && (cmd_byte == 8'h72);
    assign abort     = cmd_stop || cmd_mode;

    // Host-visible control state: streaming enable, combine mode, soft reset pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streaming  <= 1'b1;
            mode       <= (DEFAULT_MODE != 0);
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= cmd_reset;
            if (cmd_go)   streaming <= 1'b1;
            if (cmd_stop) streaming <= 1'b0;
            if (cmd_mode) mode      <= ~mode;
        end
    end

    // Combine candidates: XOR of all held words, and the current round-robin channel
    always_comb begin
        xor_word = '0;
        rr_word  = '0;
        rr_hit   = 1'b0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            xor_word = xor_word ^ hold[k];
            if (rr_ptr == PW'(k)) begin
                rr_word = word_data[k*WORD_WIDTH +: WORD_WIDTH];
                rr_hit  = word_valid[k];
            end
        end
    end

    assign emit_xor  = streaming && !mode && (pk_state == PK_IDLE) && (&fresh) && !abort;
    assign emit_rr   = streaming &&  mode && (pk_state == PK_IDLE) && rr_hit && !abort;
    assign emit      = emit_xor || emit_rr;
    assign emit_word = mode ? rr_word : xor_word;

    // XOR collector: per-channel holding register and fresh flag; a new word beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh <= '0;
            for (int k = 0; k < N_CHANNELS; k++) hold[k] <= '0;
        end else begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (word_valid[k] && !mode) hold[k] <= word_data[k*WORD_WIDTH +: WORD_WIDTH];
                if (abort)                       fresh[k] <= 1'b0;
                else if (word_valid[k] && !mode) fresh[k] <= 1'b1;
                else if (emit_xor)               fresh[k] <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances on every accepted word and restarts on a mode change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (cmd_mode) begin
            rr_ptr <= '0;
        end else if (emit_rr) begin
            rr_ptr <= (rr_ptr == PW'(N_CHANNELS - 1)) ? '0 : rr_ptr + PW'(1);
        end
    end

    // Packer FSM: latch an emitted word, then shift one byte per cycle into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_state <= PK_IDLE;
            pk_word  <= '0;
            pk_idx   <= '0;
        end else if (abort) begin
            pk_state <= PK_IDLE;
            pk_idx   <= '0;
        end else begin
            case (pk_state)
                PK_IDLE: begin
                    if (emit) begin
                        pk_word  <= emit_word;
                        pk_idx   <= '0;
                        pk_state <= PK_PUSH;
                    end
                end
                PK_PUSH: begin
                    pk_word <= pk_word >> 8;
                    if (pk_idx == IW'(BYTES - 1)) pk_state <= PK_IDLE;
                    else                          pk_idx   <= pk_idx + IW'(1);
                end
                default: pk_state <= PK_IDLE;
            endcase
        end
    end

    assign push    = (pk_state == PK_PUSH) && !abort;
    assign full    = (fifo_level == LW'(FIFO_DEPTH));
    assign empty   = (fifo_level == '0);
    assign pop     = (tx_state == TX_IDLE) && !empty && !tx_busy && !cmd_stop;
    assign push_ok = push && (!full || pop);

    // FIFO storage; no reset needed because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= pk_word[7:0];
    end

    // FIFO pointers and occupancy; a stop command empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (cmd_stop) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      fifo_level <= fifo_level + LW'(1);
            else if (!push_ok && pop) fifo_level <= fifo_level - LW'(1);
        end
    end

    // Sticky overflow flag: a dropped byte sets it, which beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     overflow <= 1'b0;
        else if (push && full && !pop)  overflow <= 1'b1;
        else if (cmd_clear)             overflow <= 1'b0;
    end

    // Transmitter FSM: hand the FIFO head to the UART and follow its busy handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_start <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        tx_byte  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        tx_state <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: if (tx_busy)  tx_state <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (!tx_busy) tx_state <= TX_IDLE;
                default:      tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_streamer.sv
// tb_entropy_streamer: drives random entropy words and host commands into
// entropy_streamer, emulates the UART busy handshake, and checks the
// transmitted byte stream against a word-level model of the combine rules.
module tb_entropy_streamer;

    localparam int NCH   = 2;
    localparam int WW    = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  word_valid;
    logic [31:0] word_data;
    logic        rx_received;
    logic [7:0]  rx_byte;
    logic        uart_busy;
    logic        hold_busy;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        soft_reset;
    logic        streaming;
    logic        mode;
    logic        overflow;
    logic [4:0]  fifo_level;

    int          total = 0;
    int          bad = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    bit          capped = 1'b0;
    int          held = 0;
    bit          exp_ovf = 1'b0;
    int          rr_p = 0;
    logic [7:0]  first_byte;

    assign tx_busy = uart_busy | hold_busy;

    entropy_streamer #(
        .N_CHANNELS(NCH),
        .WORD_WIDTH(WW),
        .FIFO_DEPTH(DEPTH),
        .DEFAULT_MODE(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .word_valid(word_valid),
        .word_data(word_data),
        .rx_received(rx_received),
        .rx_byte(rx_byte),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .soft_reset(soft_reset),
        .streaming(streaming),
        .mode(mode),
        .overflow(overflow),
        .fifo_level(fifo_level)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // UART stand-in: record each requested byte and stay busy for a random time
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tx_start === 1'b1) begin
                obs_q.push_back(tx_byte);
                @(posedge clk);
                #2;
                uart_busy = 1'b1;
                repeat ($urandom_range(4, 1)) @(posedge clk);
                #2;
                uart_busy = 1'b0;
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] data);
        word_valid = valid;
        word_data  = data;
        stepClk();
        word_valid = 2'b00;
        word_data  = $urandom;
    endtask

    task automatic sendCmd(input logic [7:0] b);
        rx_received = 1'b1;
        rx_byte     = b;
        stepClk();
        rx_received = 1'b0;
        rx_byte     = 8'($urandom);
    endtask

    // Model: one combined word becomes two bytes, LSB first, limited by FIFO room when capped
    function automatic void modelWord(input logic [15:0] w);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            if (!capped || held < DEPTH) begin
                exp_q.push_back(b);
                held++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endfunction

    task automatic xorRound(input logic [15:0] w0, input logic [15:0] w1, input bit ch1_first, input bit overwrite);
        if (ch1_first) begin
            applyStimulus(2'b10, {w1, 16'($urandom)});
            applyStimulus(2'b01, {16'($urandom), w0});
        end else begin
            if (overwrite) applyStimulus(2'b01, 32'($urandom));
            applyStimulus(2'b01, {16'($urandom), w0});
            applyStimulus(2'b10, {w1, 16'($urandom)});
        end
        modelWord(w0 ^ w1);
        repeat (4) stepClk();
    endtask

    task automatic rrRound(input logic [15:0] w, input int decoy);
        int          other;
        logic [1:0]  v;
        logic [31:0] d;
        other = 1 - rr_p;
        if (decoy == 1) applyStimulus(2'(1 << other), 32'($urandom));
        v = 2'(1 << rr_p);
        if (decoy == 2) v = 2'b11;
        d = 32'($urandom);
        if (rr_p == 0) d[15:0] = w;
        else           d[31:16] = w;
        applyStimulus(v, d);
        modelWord(w);
        rr_p = (rr_p + 1) % NCH;
        repeat (4) stepClk();
    endtask

    task automatic drain();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 6 && n < 1000) begin
            stepClk();
            n++;
            if (fifo_level == 0 && tx_busy == 1'b0 && tx_start == 1'b0) quiet++;
            else quiet = 0;
        end
        checkOutput("drain_settled", 32'(quiet >= 6), 32'd1);
    endtask

    task automatic compareQueues(input string tag);
        checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
        exp_q.delete();
        obs_q.delete();
    endtask

    // Directed sequence of phases, each mixing fixed and random words
    initial begin
        word_valid  = 2'b00;
        word_data   = 32'h0;
        rx_received = 1'b0;
        rx_byte     = 8'h00;
        hold_busy   = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_streaming", streaming, 1);
        checkOutput("rst_mode", mode, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_byte", tx_byte, 0);
        checkOutput("rst_soft_reset", soft_reset, 0);
        rst_n = 1'b1;
        stepClk();

        // XOR mode, fixed words: 0x1234 ^ 0x00FF = 0x12CB
        applyStimulus(2'b01, {16'h0000, 16'h1234});
        applyStimulus(2'b10, {16'h00FF, 16'h0000});
        exp_q.push_back(8'hCB);
        exp_q.push_back(8'h12);
        stepClk();
        stepClk();
        checkOutput("xor_first_push_level", fifo_level, 1);
        drain();
        compareQueues("xor_directed");

        // XOR mode, random words, random order and overwrites
        for (int i = 0; i < 6; i++)
            xorRound(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        drain();
        compareQueues("xor_random");

        // Round-robin mode
        sendCmd(8'h6D);
        stepClk();
        checkOutput("mode_toggle_rr", mode, 1);
        rr_p = 0;
        applyStimulus(2'b10, {16'h9999, 16'h0000});
        repeat (3) stepClk();
        rrRound(16'hAAAA, 0);
        rrRound(16'h5555, 0);
        drain();
        compareQueues("rr_directed");
        for (int i = 0; i < 6; i++)
            rrRound(16'($urandom), int'($urandom_range(2, 0)));
        drain();
        compareQueues("rr_random");

        // Overflow with the UART held busy, then clear
        sendCmd(8'h6D);
        stepClk();
        checkOutput("mode_toggle_xor", mode, 0);
        hold_busy = 1'b1;
        capped    = 1'b1;
        held      = 0;
        exp_ovf   = 1'b0;
        stepClk();
        for (int i = 0; i < 10; i++)
            xorRound(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        checkOutput("ovf_level", fifo_level, DEPTH);
        checkOutput("ovf_flag", overflow, 32'(exp_ovf));
        sendCmd(8'h63);
        checkOutput("ovf_clear_pending", overflow, 1);
        stepClk();
        checkOutput("ovf_cleared", overflow, 0);
        hold_busy = 1'b0;
        capped    = 1'b0;
        drain();
        compareQueues("ovf_kept");

        // Stop flushes a partly drained FIFO; words are ignored until restart
        hold_busy = 1'b1;
        stepClk();
        for (int i = 0; i < 3; i++)
            xorRound(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        checkOutput("stop_level6", fifo_level, 6);
        hold_busy = 1'b0;
        stepClk();
        hold_busy = 1'b1;
        checkOutput("stop_level5", fifo_level, 5);
        sendCmd(8'h73);
        stepClk();
        checkOutput("stop_flush", fifo_level, 0);
        checkOutput("stop_streaming", streaming, 0);
        first_byte = exp_q[0];
        exp_q.delete();
        exp_q.push_back(first_byte);
        hold_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            word_valid = 2'(i % 2);
            word_data  = $urandom;
            stepClk();
        end
        word_valid = 2'b00;
        repeat (10) stepClk();
        checkOutput("stop_level_idle", fifo_level, 0);
        compareQueues("stop_inflight");
        sendCmd(8'h67);
        stepClk();
        checkOutput("go_streaming", streaming, 1);
        xorRound(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        drain();
        compareQueues("go_resume");

        // Soft reset pulse leaves state untouched
        hold_busy = 1'b1;
        stepClk();
        xorRound(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        checkOutput("sr_level_before", fifo_level, 2);
        sendCmd(8'h72);
        checkOutput("sr_not_yet", soft_reset, 0);
        stepClk();
        checkOutput("sr_pulse", soft_reset, 1);
        stepClk();
        checkOutput("sr_single", soft_reset, 0);
        checkOutput("sr_level_kept", fifo_level, 2);
        checkOutput("sr_mode_kept", mode, 0);

        // Asynchronous reset while transmitting and packing
        hold_busy = 1'b0;
        stepClk();
        applyStimulus(2'b01, 32'($urandom));
        applyStimulus(2'b10, 32'($urandom));
        stepClk();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_tx_start", tx_start, 0);
        checkOutput("arst_tx_byte", tx_byte, 0);
        checkOutput("arst_level", fifo_level, 0);
        checkOutput("arst_streaming", streaming, 1);
        checkOutput("arst_mode", mode, 0);
        checkOutput("arst_overflow", overflow, 0);
        checkOutput("arst_soft_reset", soft_reset, 0);
        exp_q.delete();
        obs_q.delete();
        rr_p = 0;
        repeat (3) stepClk();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stepClk();
            checkOutput("post_rst_idle", tx_start, 0);
        end
        compareQueues("post_rst_quiet");
        xorRound(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        drain();
        compareQueues("post_rst_stream");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entropy_streamer.md
Name: entropy_streamer

Overview:
Multi-channel successor to the single-LFSR-to-UART path. It takes N_CHANNELS of raw entropy words, combines them by XOR or interleaves them round-robin, and serialises each word into bytes. The bytes are buffered in a FIFO and fed to the uart transmitter through its transmit/is_transmitting handshake. It also decodes single-byte host commands received over the UART: start, stop, mode, clear and reset.

Parameters:
N_CHANNELS, 2, number of entropy sources (1..8)
WORD_WIDTH, 16, bits per source word; must be a multiple of 8
FIFO_DEPTH, 16, byte FIFO depth; power of 2, at least 2
DEFAULT_MODE, 0, combine mode after reset: 0 = XOR, 1 = round-robin

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
word_valid  in  N_CHANNELS  per-channel one-cycle strobe: new word available
word_data  in  N_CHANNELS*WORD_WIDTH  channel k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]
rx_received  in  1  one-cycle strobe: UART byte received
rx_byte  in  8  received byte, valid with rx_received
tx_busy  in  1  uart is_transmitting
tx_start  out  1  one-cycle transmit request
tx_byte  out  8  byte to transmit, held stable from tx_start until tx_busy falls
soft_reset  out  1  one-cycle pulse requesting system reset
streaming  out  1  streaming enabled
mode  out  1  current combine mode
overflow  out  1  sticky flag: a byte was dropped because the FIFO was full
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): streaming=1, mode=DEFAULT_MODE, overflow=0, fifo_level=0, tx_start=0, tx_byte=0, soft_reset=0.
- Reset also clears the FIFO pointers, all fresh flags, the round-robin pointer, and returns the packer and transmitter FSMs to IDLE.
- Collector, mode 0 (XOR):
  - Per channel: a holding register plus a fresh flag. word_valid[k] loads the register and sets fresh[k]; a later valid overwrites it.
  - When all fresh flags are set and the packer is IDLE, the collector emits the XOR of all holding registers and clears every fresh flag in the same cycle.
  - A word_valid arriving in that same cycle wins: that channel's register loads and its flag stays set.
- Collector, mode 1 (round-robin):
  - Pointer p starts at 0.
  - When the packer is IDLE and word_valid[p] is high, the collector emits word_data of channel p, and p advances modulo N_CHANNELS.
  - word_valid on any other channel, or while the packer is busy, is discarded.
- Collector gating: no word is emitted while streaming=0.
- Packer FSM:
  - IDLE: on an emitted word, latch it and go to PUSH with idx=0.
  - PUSH: each cycle, push byte idx, LSB first (bits [8*idx +: 8]), into the FIFO. After byte WORD_WIDTH/8-1 is pushed, return to IDLE.
  - Latency: first byte reaches the FIFO 1 cycle after the word is emitted.
- FIFO:
  - A push while full drops the byte and sets overflow. The packer still advances.
  - Simultaneous push and pop while full is accepted; fifo_level is unchanged.
  - A pop while empty never occurs.
- Transmitter FSM:
  - IDLE: when the FIFO is non-empty and tx_busy=0, drive tx_byte=FIFO head, pulse tx_start for 1 cycle, pop the FIFO, go to WAIT_BUSY.
  - WAIT_BUSY: when tx_busy=1, go to WAIT_DONE.
  - WAIT_DONE: when tx_busy=0, return to IDLE.
  - Back-to-back bytes therefore have at least 1 idle cycle between tx_busy falling and the next tx_start.
- Commands: decoded 1 cycle after rx_received; all other byte values are ignored.
  - 0x67 'g': streaming=1.
  - 0x73 's': streaming=0. Flushes the FIFO (level 0), aborts the packer to IDLE and clears the fresh flags. A byte already handed to the UART (transmitter in WAIT_*) completes normally.
  - 0x6D 'm': toggle mode. Clears the fresh flags, sets p=0 and aborts the packer to IDLE.
  - 0x63 'c': overflow=0. If an overflowing push happens in the same cycle, set wins.
  - 0x72 'r': soft_reset=1 for exactly 1 cycle; no internal state change.

Test Plan:
- Reset, then N_CHANNELS=2, WORD_WIDTH=16, mode 0: ch0=0x1234 and ch1=0x00FF on different cycles -> FIFO receives 0xCB then 0x12; tx_start pulses twice with tx_byte 0xCB, 0x12.
- Mode 1 after 'm' (0x6D): valid on ch1 first (discarded), then ch0=0xAAAA, ch1=0x5555 -> bytes 0xAA,0xAA,0x55,0x55 in order; mode=1.
- Hold tx_busy=1 and stream with FIFO_DEPTH=16 -> fifo_level saturates at 16 and overflow=1; send 'c' -> overflow=0 two cycles after rx_received.
- FIFO holding 5 bytes, send 's' -> fifo_level=0 and streaming=0; no further tx_start even with word_valid toggling; send 'g' -> streaming resumes.
- rx_byte=0x72 with rx_received -> soft_reset high for exactly 1 cycle; fifo_level and mode unchanged.
- Assert rst_n low mid-transmission with the packer in PUSH -> all outputs immediately at reset values; tx_start stays 0 until new words arrive.
